// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: sums a 2x2 product array into four elements, double-buffers
// result matrices and streams them row-major over valid/ready. Optional: MRS_SATURATE_EN.
module matrix_result_streamer #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] A_E,
    input  logic [PW-1:0] B_G,
    input  logic [PW-1:0] C_E,
    input  logic [PW-1:0] D_G,
    input  logic [PW-1:0] A_F,
    input  logic [PW-1:0] B_H,
    input  logic [PW-1:0] C_F,
    input  logic [PW-1:0] D_H,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW:0]   out_data,
    output logic [1:0]    out_idx,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    frame_cnt
);

    // state  | meaning
    // IDLE   | no buffered matrix, outputs held at zero
    // STREAM | at least one matrix buffered, presenting slot[rd_ptr][elem]
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [PW:0] slot [2][4];
    logic [PW:0] sum [4];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [1:0]  elem;
    logic        accept;
    logic        pop;
    logic        pop_last;

    // sum[PW] set means the sum is above 2^PW-1, which is the clamp condition
    function automatic logic [PW:0] add_elem(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef MRS_SATURATE_EN
        if (s[PW]) begin
            s = {1'b0, {PW{1'b1}}};
        end
`endif
        return s;
    endfunction

    always_comb begin
        sum[0] = add_elem(A_E, B_G);
        sum[1] = add_elem(A_F, B_H);
        sum[2] = add_elem(C_E, D_G);
        sum[3] = add_elem(C_F, D_H);
    end

    // in_ready looks only at the registered count, never at out_ready
    assign in_ready = (count < 2'd2);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign pop_last = pop && (elem == 2'd3);

    always_comb begin
        count_nxt = count;
        if (accept && !pop_last) begin
            count_nxt = count + 2'd1;
        end else if (!accept && pop_last) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count_nxt != 2'd0) state_nxt = STREAM;
            STREAM:  if (count_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        if (state == STREAM) begin
            out_valid = 1'b1;
            out_data  = slot[rd_ptr][elem];
            out_idx   = elem;
            out_last  = (elem == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            elem      <= 2'd0;
            frame_cnt <= 8'd0;
        end else begin
            count <= count_nxt;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                elem <= elem + 2'd1;
                if (elem == 2'd3) begin
                    rd_ptr    <= ~rd_ptr;
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // slot storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                slot[wr_ptr][i] <= sum[i];
            end
        end
    end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Consumer stage for the 2x2 multiplier's product array. It accepts the eight registered partial products of one C = [A B; C D] x [E F; G H] multiplication as a single beat. It adds them pairwise into the four result elements and buffers up to two result matrices. It then streams the elements out one per beat, in row-major order, over a valid/ready handshake.

## Interface
Parameters:
- PW, 16, width of each incoming partial product; result elements are PW+1 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- A_E, B_G, C_E, D_G, A_F, B_H, C_F, D_H  input  PW each  partial products of one matrix.
- in_valid  input  1  the eight products form a valid beat.
- in_ready  output  1  a beat is accepted this cycle; high when buffer count < 2.
- out_data  output  PW+1  current result element.
- out_idx  output  2  element index: 0=C00, 1=C01, 2=C10, 3=C11.
- out_last  output  1  high with index 3 (last element of the matrix).
- out_valid  output  1  out_data, out_idx and out_last are valid.
- out_ready  input  1  downstream takes the element.
- frame_cnt  output  8  count of fully streamed matrices, wraps 255 -> 0.

## Operation
- On accept (in_valid && in_ready), compute the four sums at full width and store them in slot[wr_ptr]; then toggle wr_ptr and increment count:
  - C00 = A_E + B_G
  - C01 = A_F + B_H
  - C10 = C_E + D_G
  - C11 = C_F + D_H
- Buffer: two slots, each 4 x (PW+1). Pointers wr_ptr and rd_ptr are 1 bit each; count ranges 0..2.
- Output FSM states:
  - IDLE (count==0): out_valid=0.
  - STREAM (count>0): out_valid=1, out_data = slot[rd_ptr][elem], out_idx = elem.
- On a pop (out_valid && out_ready), elem increments.
  - If elem==3: elem returns to 0, rd_ptr toggles, count decrements, and frame_cnt increments.
  - STREAM returns to IDLE only if count becomes 0.
- Accept and final pop in the same cycle: count is unchanged; both pointers advance.
- in_ready depends only on registered count. It has no combinational path from out_ready, so with count==2 a same-cycle final pop does not raise in_ready until the next cycle.
- out_valid, once high, holds with stable data until the element is popped.
- While out_valid=0, out_data, out_idx and out_last are 0.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0, out_data=0, out_idx=0, out_last=0
  - frame_cnt=0
  - count=0, elem=0, both pointers 0
  - slot contents don't-care
- Latency: with an empty buffer, a matrix accepted at edge N presents C00 with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: with out_ready held high, 4 cycles per matrix; input is accepted every 4 cycles at steady state.
- Reset asserted mid-stream aborts the current matrix and discards both slots. No partial frame is counted.

## Configuration
- Macro MRS_SATURATE_EN.
- Defined: each element saturates to 2^PW-1 when its sum exceeds it, so the MSB of out_data is always 0.
- Undefined: the full PW+1-bit sum is output unmodified.

## Test plan
- Single matrix, PW=16, out_ready=1:
  - Stimulus: products A_E=5, B_G=14, A_F=6, B_H=16, C_E=15, D_G=28, C_F=18, D_H=32.
  - Response: out_data 19, 22, 43, 50 with out_idx 0..3 on consecutive cycles; out_last only with 50; frame_cnt=1.
- Backpressure:
  - Stimulus: same matrix, out_ready toggled 1,0,0,1,...
  - Response: each element held stable while out_ready=0; order and values unchanged; no duplicated or dropped element.
- Full buffer:
  - Stimulus: three back-to-back in_valid beats with out_ready=0.
  - Response: the first two are accepted; in_ready=0 from the cycle after the second accept. After releasing out_ready, the third is accepted only in the cycle after the first frame's final pop, and all 12 elements appear in order.
- Max values:
  - Stimulus: all products = 65025.
  - Response: each element = 130050 without MRS_SATURATE_EN; 65535 with it.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously during out_idx=2 of the first frame, with a second frame buffered.
  - Response: out_valid=0, in_ready=1 and frame_cnt=0 immediately, with no clock edge. After release, a new matrix streams correctly starting at out_idx=0.
- Frame counter wrap:
  - Stimulus: stream 256 matrices.
  - Response: frame_cnt reads 0 after the 256th last-element pop.
